// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state encoding
// and the address-width helper used to size every address bus.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: flattened read ports, one write port and the
// clear request / busy pair. ra/rd port i sits at [i*AW +: AW] / [i*WIDTH +: WIDTH].
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = addr_width(DEPTH);

  // Handshake: no valid/ready. Writes commit on any rising edge with we=1 while
  // busy=0; clr is a one-cycle pulse; while busy=1, we and clr are ignored.
  logic [NREAD*AW-1:0]    ra;
  logic [NREAD*WIDTH-1:0] rd;
  logic [AW-1:0]          wa;
  logic [WIDTH-1:0]       wd;
  logic                   we;
  logic                   clr;
  logic                   busy;

  modport master (output ra, wa, wd, we, clr, input rd, busy);
  modport slave  (input ra, wa, wd, we, clr, output rd, busy);
endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: word select, register 0 forced to zero and,
// when REGFILE_BYPASS_EN is defined, write-through of the pending write data.
module register_file_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] i_regs,
  input  logic [AW-1:0]          i_ra,
`ifdef REGFILE_BYPASS_EN
  input  logic                   i_byp_en,
  input  logic [AW-1:0]          i_wa,
  input  logic [WIDTH-1:0]       i_wd,
`endif
  output logic [WIDTH-1:0]       o_rd
);

   logic [WIDTH-1:0] w_words [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
      assign w_words[g] = i_regs[g*WIDTH +: WIDTH];
   end

   always_comb begin
      o_rd = w_words[i_ra];
`ifdef REGFILE_BYPASS_EN
      if (i_byp_en && (i_ra == i_wa)) o_rd = i_wd;
`endif
      if (i_ra == '0) o_rd = '0;
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with a sequential clear sweep (IDLE/CLEAR FSM).
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-through reads.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  register_file_mp_if.slave   bus,
  output state_e              o_state
);

   localparam int AW = addr_width(DEPTH);

   logic [WIDTH-1:0]       r_regs [DEPTH];
   state_e                 r_state;
   logic [AW-1:0]          r_cnt;
   logic [DEPTH*WIDTH-1:0] w_regs_flat;
   logic                   w_wr_en;

   assign w_wr_en  = bus.we && (r_state == IDLE) && (bus.wa != '0);
   assign bus.busy = (r_state == CLEAR);
   assign o_state  = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_wr_en) r_regs[bus.wa] <= bus.wd;
               if (bus.clr) begin
                  r_state <= CLEAR;
                  r_cnt   <= AW'(1);
               end
            end
            CLEAR: begin
               // Register 0 is never stored, so the sweep starts at 1 and ends at DEPTH-1.
               r_regs[r_cnt] <= '0;
               if (r_cnt == AW'(DEPTH - 1)) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + AW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign w_regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_rport
      register_file_read_port #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_rport (
         .i_regs   (w_regs_flat),
         .i_ra     (bus.ra[p*AW +: AW]),
`ifdef REGFILE_BYPASS_EN
         .i_byp_en (w_wr_en),
         .i_wa     (bus.wa),
         .i_wd     (bus.wd),
`endif
         .o_rd     (bus.rd[p*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: default 32x32x2 instance plus a
// 16-bit, 8-deep, 3-port instance sharing the clock and reset.
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int N  = 2;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_file_mp_if #(.WIDTH(W), .DEPTH(D), .NREAD(N)) bus ();
  register_file_mp_if #(.WIDTH(16), .DEPTH(8), .NREAD(3)) bus_s ();
  state_e w_state;
  state_e w_state_s;

  register_file_mp #(.WIDTH(W), .DEPTH(D), .NREAD(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_state(w_state)
  );
  register_file_mp #(.WIDTH(16), .DEPTH(8), .NREAD(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .o_state(w_state_s)
  );

  logic [W-1:0] mdl [D];
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int busy_n;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int port, input int addr);
    bus.ra[port*AW +: AW] = AW'(addr);
    #1;
    exp_q.push_back(mdl[addr]);
    check(tag, bus.rd[port*W +: W], exp_q.pop_front());
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1;
    bus.wa = AW'(a);
    bus.wd = d;
    @(posedge clk);
    #1;
    if (a != 0) mdl[a] = d;
    bus.we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ra = '0; bus.wa = '0; bus.wd = '0; bus.we = 1'b0; bus.clr = 1'b0;
    bus_s.ra = '0; bus_s.wa = '0; bus_s.wd = '0; bus_s.we = 1'b0; bus_s.clr = 1'b0;
    for (int i = 0; i < D; i++) mdl[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(w_state), 32'(IDLE));
    rd_chk("rst_r1", 0, 1);

    // First write right after release, with the pre-edge read
    @(negedge clk);
    rst_n  = 1'b1;
    bus.we = 1'b1; bus.wa = AW'(1); bus.wd = 32'd69;
    bus.ra[0 +: AW] = AW'(1);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'd69);
`else
    exp_q.push_back(32'd0);
`endif
    check("pre_edge_r1", bus.rd[0 +: W], exp_q.pop_front());
    @(posedge clk);
    #1;
    mdl[1] = 32'd69;
    bus.we = 1'b0;
    rd_chk("post_edge_r1", 0, 1);

    // Writes to register 0 are discarded
    wr(0, 32'hFFFF_FFFF);
    rd_chk("r0_p0", 0, 0);
    rd_chk("r0_p1", 1, 0);

    // Random writes and reads, including both ports on one address
    for (int k = 0; k < 8; k++) begin
      int a;
      a = $urandom_range(1, D - 1);
      wr(a, $urandom);
      rd_chk("rand_p0", 0, a);
      rd_chk("rand_p1", 1, $urandom_range(0, D - 1));
      rd_chk("same_p1", 1, a);
    end

    // Full sweep with mid-sweep reads, ignored write and ignored clr
    for (int a = 1; a < D; a++) wr(a, 32'hA5);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    busy_n = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_n++;
      if (busy_n == 1) check("state_clear", 32'(w_state), 32'(CLEAR));
      if (busy_n == 10) begin
        rd_chk("mid_r5", 0, 5);
        rd_chk("mid_r20", 1, 20);
        bus.we = 1'b1; bus.wa = AW'(3); bus.wd = 32'd7;
      end
      if (busy_n == 11) bus.we = 1'b0;
      if (busy_n == 20) bus.clr = 1'b1;
      if (busy_n == 21) bus.clr = 1'b0;
      if (busy_n < D) mdl[busy_n] = '0;
    end
    bus.we = 1'b0; bus.clr = 1'b0;
    check("busy_len", 32'(busy_n), 32'd31);
    check("state_idle", 32'(w_state), 32'(IDLE));
    rd_chk("reg3_after_sweep", 0, 3);
    for (int a = 0; a < D; a++) begin
      rd_chk("swept_p0", 0, a);
      rd_chk("swept_p1", 1, a);
    end

    // Reset in the middle of a sweep
    for (int a = 1; a < 6; a++) wr(a, $urandom);
    wr(25, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    for (int t = 0; t < 10; t++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    for (int a = 0; a < D; a++) mdl[a] = '0;
    for (int a = 0; a < D; a++) rd_chk("abort_regs", 0, a);
    @(negedge clk);
    rst_n  = 1'b1;
    bus.we = 1'b1; bus.wa = AW'(2); bus.wd = 32'd9;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    mdl[2] = 32'd9;
    rd_chk("after_rst_r2", 0, 2);

    // Small instance: 3 ports, 8-deep clear
    @(negedge clk);
    bus_s.we = 1'b1; bus_s.wa = 3'd7; bus_s.wd = 16'hBEEF;
    @(negedge clk);
    bus_s.wa = 3'd1; bus_s.wd = 16'h1234;
    @(negedge clk);
    bus_s.we = 1'b0;
    bus_s.ra = {3'd1, 3'd7, 3'd7};
    #1;
    exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF); exp_q.push_back(32'h1234);
    check("s_p0", 32'(bus_s.rd[0 +: 16]), exp_q.pop_front());
    check("s_p1", 32'(bus_s.rd[16 +: 16]), exp_q.pop_front());
    check("s_p2", 32'(bus_s.rd[32 +: 16]), exp_q.pop_front());
    @(negedge clk);
    bus_s.clr = 1'b1;
    @(posedge clk);
    #1 bus_s.clr = 1'b0;
    busy_n = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!bus_s.busy) break;
      busy_n++;
    end
    check("s_busy_len", 32'(busy_n), 32'd7);
    #1;
    check("s_clr_p0", 32'(bus_s.rd[0 +: 16]), 32'd0);
    check("s_clr_p2", 32'(bus_s.rd[32 +: 16]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
